// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//   Parametrised register file with NUM_RD independent registered read ports,
//   one write port, an optional hardwired-zero entry 0, an optional
//   write-to-read bypass and a sequential bulk-clear engine.
//
// Ports
//   clk      in   clock, all state on rising edge
//   rst      in   asynchronous active-high reset (clears array, outputs, FSM)
//   rd_en    in   [NUM_RD]          per-port read enable
//   rd_addr  in   [NUM_RD*ADDR_W]   packed read addresses, port k at k*ADDR_W
//   rd_dout  out  [NUM_RD*DATA_W]   packed registered read data, port k at k*DATA_W
//   wr_en    in   write enable (dropped while busy or when a clear starts)
//   wr_addr  in   [ADDR_W] write address
//   wr_din   in   [DATA_W] write data
//   clr_req  in   single-cycle request to zero the whole array
//   busy     out  high while the clear sweep runs (exactly DEPTH cycles)
// -----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_dout,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_din,
    input  logic                       clr_req,
    output logic                       busy
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_wr_ok;
    logic                w_busy;

    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;

    // A write lands only from IDLE, never on the edge that starts a clear,
    // and never into a hardwired-zero entry 0.
    assign w_wr_ok = wr_en && !w_busy && !clr_req &&
                     !((ZERO_R0 != 0) && (wr_addr == '0));

    // Clear engine: state and sweep pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                // clr_req is ignored here; the sweep always runs to the end.
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Storage array: sweep clear has priority over the write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_din;
        end
    end

    // Read ports: select stage, then one output register per port
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic [DATA_W-1:0] r_dout_p1;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_mem[w_addr];
            if (w_busy) begin
                // Whole array is logically zero while a sweep is in flight.
                w_data = '0;
            end else if ((ZERO_R0 != 0) && (w_addr == '0)) begin
                w_data = '0;
            end else if ((BYPASS != 0) && w_wr_ok && (wr_addr == w_addr)) begin
                w_data = wr_din;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout_p1 <= '0;
            end else if (rd_en[k]) begin
                r_dout_p1 <= w_data;
            end
        end

        assign rd_dout[k*DATA_W +: DATA_W] = r_dout_p1;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instances A (bypass, zero r0) and B (read-first, plain r0) share stimulus
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] dout_a, dout_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_din;
    logic        clr_req;
    logic        busy_a, busy_b;

    // Instance C: 4 ports, 16 bit, 8 entries
    logic [3:0]  c_rd_en;
    logic [11:0] c_rd_addr;
    logic [63:0] c_dout;
    logic        c_wr_en;
    logic [2:0]  c_wr_addr;
    logic [15:0] c_wr_din;
    logic        c_clr;
    logic        c_busy;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .clr_req(clr_req), .busy(busy_a));

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_R0(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .clr_req(clr_req), .busy(busy_b));

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_R0(1), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_dout(c_dout),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_din(c_wr_din), .clr_req(c_clr), .busy(c_busy));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference for A and B
    logic [31:0] mA [32];
    logic [31:0] mB [32];
    logic [31:0] oA [2];
    logic [31:0] oB [2];
    logic        m_busy;
    int          m_ptr;

    typedef struct {
        logic [31:0] a0, a1, b0, b1;
        logic        bsy;
    } exp_t;
    exp_t q[$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mA[i] = '0;
            mB[i] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            oA[k] = '0;
            oB[k] = '0;
        end
        m_busy = 1'b0;
        m_ptr  = 0;
    endtask

    // Drive one cycle on A/B, push the model's prediction, clock, pop and compare.
    task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic clr);
        exp_t e;
        logic [4:0] ad [2];
        logic wokA, wokB;
        rd_en   = en;
        rd_addr = {a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_din  = wd;
        clr_req = clr;
        ad[0] = a0;
        ad[1] = a1;
        wokA = we && !m_busy && !clr && (wa != 5'd0);
        wokB = we && !m_busy && !clr;
        for (int k = 0; k < 2; k++) begin
            if (en[k]) begin
                if (m_busy) begin
                    oA[k] = '0;
                    oB[k] = '0;
                end else begin
                    if (ad[k] == 5'd0)                oA[k] = '0;
                    else if (wokA && wa == ad[k])     oA[k] = wd;
                    else                              oA[k] = mA[ad[k]];
                    oB[k] = mB[ad[k]];
                end
            end
        end
        if (m_busy) begin
            mA[m_ptr] = '0;
            mB[m_ptr] = '0;
            if (m_ptr == 31) m_busy = 1'b0;
            m_ptr = (m_ptr + 1) % 32;
        end else if (clr) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end else begin
            if (wokA) mA[wa] = wd;
            if (wokB) mB[wa] = wd;
        end
        e.a0 = oA[0]; e.a1 = oA[1]; e.b0 = oB[0]; e.b1 = oB[1]; e.bsy = m_busy;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_a0", {32'd0, dout_a[31:0]},  {32'd0, e.a0});
        chk("sb_a1", {32'd0, dout_a[63:32]}, {32'd0, e.a1});
        chk("sb_b0", {32'd0, dout_b[31:0]},  {32'd0, e.b0});
        chk("sb_b1", {32'd0, dout_b[63:32]}, {32'd0, e.b1});
        chk("sb_busy_a", {63'd0, busy_a}, {63'd0, e.bsy});
        chk("sb_busy_b", {63'd0, busy_b}, {63'd0, e.bsy});
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic cstep(input logic [3:0] en, input logic [11:0] ad, input logic we,
                         input logic [2:0] wa, input logic [15:0] wd, input logic clr);
        c_rd_en   = en;
        c_rd_addr = ad;
        c_wr_en   = we;
        c_wr_addr = wa;
        c_wr_din  = wd;
        c_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] eA0, eA1, eB0;
    } vec_t;
    vec_t tbl [8];

    int cnt;

    initial begin
        // Directed vectors with hand-derived expectations (A bypass/zero-r0, B read-first)
        tbl[0] = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        tbl[1] = '{2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{2'b00, 5'd9, 5'd10,1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3] = '{2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tbl[4] = '{2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0,        32'h12345678, 32'h12345678, 32'h12345678};
        tbl[5] = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[6] = '{2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF};
        tbl[7] = '{2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 32'hAAAA5555, 32'h0,        32'h0,        32'hFFFFFFFF};

        rst = 1'b1;
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_din = '0; clr_req = 1'b0;
        c_rd_en = '0; c_rd_addr = '0; c_wr_en = 1'b0; c_wr_addr = '0; c_wr_din = '0; c_clr = 1'b0;
        model_reset();
        #12;
        chk("rst_dout_a", dout_a, 64'd0);
        chk("rst_dout_b", dout_b, 64'd0);
        chk("rst_busy",   {62'd0, busy_a, busy_b}, 64'd0);
        chk("rst_dout_c", c_dout, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Every entry reads zero after reset
        for (int i = 0; i < 32; i++) drive(2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0, 1'b0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].en, tbl[i].a0, tbl[i].a1, tbl[i].we, tbl[i].wa, tbl[i].wd, 1'b0);
            chk($sformatf("tbl%0d_a0", i), {32'd0, dout_a[31:0]},  {32'd0, tbl[i].eA0});
            chk($sformatf("tbl%0d_a1", i), {32'd0, dout_a[63:32]}, {32'd0, tbl[i].eA1});
            chk($sformatf("tbl%0d_b0", i), {32'd0, dout_b[31:0]},  {32'd0, tbl[i].eB0});
        end

        // Fill with address+1, then sweep; write and reads inside the sweep
        for (int i = 0; i < 32; i++) drive(2'b00, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i + 1), 1'b0);
        drive(2'b11, 5'd3, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        cnt = busy_a ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) drive(2'b11, 5'd3, 5'd30, 1'b1, 5'd3, 32'h55AA55AA, 1'b0);
            else if (i == 5) drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
            else idle();
            if (busy_a) cnt++;
            else break;
        end
        chk("busy_len_a", 64'(cnt), 64'd32);
        for (int i = 0; i < 32; i++) drive(2'b11, 5'(i), 5'(i), 1'b0, 5'd0, 32'd0, 1'b0);
        chk("post_clr_3", dout_a, 64'd0);

        // Refill, latch nonzero outputs, clear with a competing write, reset mid-sweep
        for (int i = 1; i < 32; i++) drive(2'b00, 5'd0, 5'd0, 1'b1, 5'(i), ~32'(i), 1'b0);
        drive(2'b11, 5'd4, 5'd20, 1'b1, 5'd4, 32'h0BAD0BAD, 1'b1);
        for (int i = 0; i < 9; i++) idle();
        chk("busy_before_rst", {63'd0, busy_a}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {62'd0, busy_a, busy_b}, 64'd0);
        chk("async_rst_dout_a", dout_a, 64'd0);
        chk("async_rst_dout_b", dout_b, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) drive(2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0);
        drive(2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("after_rst_rd9", dout_a, {32'hCAFEF00D, 32'hCAFEF00D});

        // Instance C: four ports on distinct addresses, then a sweep with a repeated request
        for (int i = 1; i < 8; i++) cstep(4'b0000, 12'd0, 1'b1, 3'(i), 16'(i * 16'h1001), 1'b0);
        cstep(4'b1111, {3'd3, 3'd5, 3'd1, 3'd7}, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("c_port0", {48'd0, c_dout[15:0]},  64'h7007);
        chk("c_port1", {48'd0, c_dout[31:16]}, 64'h1001);
        chk("c_port2", {48'd0, c_dout[47:32]}, 64'h5005);
        chk("c_port3", {48'd0, c_dout[63:48]}, 64'h3003);
        cstep(4'b0000, 12'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        cnt = c_busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            cstep(4'b0000, 12'd0, 1'b0, 3'd0, 16'd0, (i == 3));
            if (c_busy) cnt++;
            else break;
        end
        chk("c_busy_len", 64'(cnt), 64'd8);
        cstep(4'b1111, {3'd3, 3'd5, 3'd1, 3'd7}, 1'b0, 3'd0, 16'd0, 1'b0);
        chk("c_post_clr", c_dout, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
